// File: rtl/des_round_if.sv
// Handshake and datapath-control bundle between a DES round controller and its requester/datapath.
interface des_round_if;
  logic        start_valid;
  logic        start_ready;
  logic        mode;
  logic        abort;
  logic        dp_load;
  logic        dp_round_en;
  logic [3:0]  dp_round_idx;
  logic [1:0]  dp_shift;
  logic        dp_shift_dir;
  logic        dp_final;
  logic        out_valid;
  logic        out_ready;
  logic        out_mode;
  logic        busy;
  logic [15:0] blk_count;

  modport master (
    output start_valid, mode, abort, out_ready,
    input  start_ready, dp_load, dp_round_en, dp_round_idx, dp_shift, dp_shift_dir,
           dp_final, out_valid, out_mode, busy, blk_count
  );

  modport slave (
    input  start_valid, mode, abort, out_ready,
    output start_ready, dp_load, dp_round_en, dp_round_idx, dp_shift, dp_shift_dir,
           dp_final, out_valid, out_mode, busy, blk_count
  );
endinterface

// File: rtl/des_round_ctrl.sv
// DES round sequencer: load, 16 Feistel rounds with key-rotate schedule, final capture, result hold.
module des_round_ctrl #(
  parameter int unsigned LOAD_CYCLES = 1
) (
  input logic        clk,
  input logic        rst,
  des_round_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ROUND, S_FINAL, S_HOLD} state_t;

  localparam logic [1:0] LOAD_M1 = 2'(LOAD_CYCLES - 1);

  state_t      state_q, state_d;
  logic [1:0]  load_cnt_q, load_cnt_d;
  logic [3:0]  round_idx_q, round_idx_d;
  logic        mode_q, mode_d;
  logic        dp_load_q, dp_load_d;
  logic        round_en_q, round_en_d;
  logic [1:0]  shift_q, shift_d;
  logic        shift_dir_q, shift_dir_d;
  logic        final_q, final_d;
  logic        out_valid_q, out_valid_d;
  logic        busy_q, busy_d;
  logic [15:0] blk_count_q, blk_count_d;
  logic        start_ready;
  logic        accept;
  logic        handshake;

  // Decrypt runs the key schedule backwards, so round 0 needs no rotation.
  function automatic logic [1:0] shift_of(input logic [3:0] idx, input logic dec);
    if (dec && idx == 4'd0) return 2'd0;
    if (idx == 4'd0 || idx == 4'd1 || idx == 4'd8 || idx == 4'd15) return 2'd1;
    return 2'd2;
  endfunction

  assign start_ready = ((state_q == S_IDLE) | ((state_q == S_HOLD) & bus.out_ready)) & ~bus.abort;
  assign accept      = bus.start_valid & start_ready;
  assign handshake   = out_valid_q & bus.out_ready;

  always_comb begin
    state_d     = state_q;
    load_cnt_d  = load_cnt_q;
    round_idx_d = '0;
    mode_d      = mode_q;
    if (bus.abort) begin
      state_d    = S_IDLE;
      load_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: if (accept) begin
          state_d    = S_LOAD;
          load_cnt_d = LOAD_M1;
          mode_d     = bus.mode;
        end
        S_LOAD: begin
          if (load_cnt_q == 2'd0) state_d = S_ROUND;
          else                    load_cnt_d = load_cnt_q - 2'd1;
        end
        S_ROUND: begin
          if (round_idx_q == 4'd15) state_d = S_FINAL;
          else                      round_idx_d = round_idx_q + 4'd1;
        end
        S_FINAL: state_d = S_HOLD;
        S_HOLD: if (bus.out_ready) begin
          if (accept) begin
            state_d    = S_LOAD;
            load_cnt_d = LOAD_M1;
            mode_d     = bus.mode;
          end else begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Outputs are decoded from next state so they appear registered in the cycle they apply.
    dp_load_d   = (state_d == S_LOAD) && (state_q != S_LOAD);
    round_en_d  = (state_d == S_ROUND);
    shift_d     = 2'd0;
    shift_dir_d = 1'b0;
    if (state_d == S_ROUND) begin
      shift_d     = shift_of(round_idx_d, mode_d);
      shift_dir_d = mode_d;
    end
    final_d     = (state_d == S_FINAL);
    out_valid_d = (state_d == S_HOLD);
    busy_d      = (state_d != S_IDLE);
    blk_count_d = blk_count_q + {15'd0, handshake};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      load_cnt_q  <= '0;
      round_idx_q <= '0;
      mode_q      <= 1'b0;
      dp_load_q   <= 1'b0;
      round_en_q  <= 1'b0;
      shift_q     <= '0;
      shift_dir_q <= 1'b0;
      final_q     <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      blk_count_q <= '0;
    end else begin
      state_q     <= state_d;
      load_cnt_q  <= load_cnt_d;
      round_idx_q <= round_idx_d;
      mode_q      <= mode_d;
      dp_load_q   <= dp_load_d;
      round_en_q  <= round_en_d;
      shift_q     <= shift_d;
      shift_dir_q <= shift_dir_d;
      final_q     <= final_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      blk_count_q <= blk_count_d;
    end
  end

  assign bus.start_ready  = start_ready;
  assign bus.dp_load      = dp_load_q;
  assign bus.dp_round_en  = round_en_q;
  assign bus.dp_round_idx = round_idx_q;
  assign bus.dp_shift     = shift_q;
  assign bus.dp_shift_dir = shift_dir_q;
  assign bus.dp_final     = final_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_mode     = mode_q;
  assign bus.busy         = busy_q;
  assign bus.blk_count    = blk_count_q;

endmodule
